dbg_cmd_decoder: RTL

- Parametrised clock-domain-side debug command receiver for the CPU debug slave.
- Accepts update events from the JTAG shift-register domain as a toggle, synchronises them into clk, and queues {ir, sr} snapshots in a small FIFO.
- Presents queued commands with a valid/ready handshake and decodes them into per-IR take_action / take_no_action strobes.
- Differs from the fixed 2-bit-IR, unbuffered decoder: IR width, data width, sync depth and queue depth are parametrised, back-to-back updates are buffered, and drops are reported.

---
 rtl/dbg_cmd_decoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dbg_cmd_decoder.sv
// dbg_cmd_decoder
//   Receives debug commands from the JTAG shift-register domain on the clk side.
//   Each JTAG update-DR flips upd_toggle. The flip is synchronised into clk and
//   edge-detected. The matching {ir_in, sr} snapshot is captured and queued in a
//   small FIFO. The head command is presented with a valid/ready handshake and
//   decoded into one-hot take_action / take_no_action strobes.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   upd_toggle      flips once per JTAG update (asynchronous to clk)
//   ir_in, sr       IR / shift-register snapshot belonging to the update
//   out_ready       consumer accepts the head command
//   ovf_clr         clears overflow and drop_cnt
//   out_valid       a head command is available
//   jdo, jir        head command data / IR (held stable while out_valid=1)
//   take_action     one-hot on jir during fire, when jdo[DATA_W-1]=1
//   take_no_action  one-hot on jir during fire, when jdo[DATA_W-1]=0
//   level           FIFO occupancy
//   overflow        sticky: an update was dropped because the FIFO was full
//   drop_cnt        saturating count of dropped updates
//
// Handshake: a command transfers (fire) in any cycle where out_valid and
// out_ready are both high. The consumer may hold out_ready high or low freely.
// out_valid does not depend on out_ready, and jdo/jir stay stable until fire.
module dbg_cmd_decoder #(
    parameter int IR_W        = 2,
    parameter int DATA_W      = 38,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       upd_toggle,
    input  logic [IR_W-1:0]            ir_in,
    input  logic [DATA_W-1:0]          sr,
    input  logic                       out_ready,
    input  logic                       ovf_clr,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          jdo,
    output logic [IR_W-1:0]            jir,
    output logic [(1<<IR_W)-1:0]       take_action,
    output logic [(1<<IR_W)-1:0]       take_no_action,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = IR_W + DATA_W;
    localparam int ARM_W   = $clog2(SYNC_STAGES + 2);

    // Toggle synchroniser and edge detect
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_tog;
    logic                   prev_tog;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   evt;

    assign sync_tog = sync_q[SYNC_STAGES-1];
    // While arming, prev_tog simply tracks sync_tog. A toggle that sat at 1
    // through reset is therefore absorbed instead of being seen as an edge.
    assign evt = (arm_cnt == '0) && (sync_tog != prev_tog);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            prev_tog <= 1'b0;
            arm_cnt  <= ARM_W'(SYNC_STAGES + 1);
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], upd_toggle};
            prev_tog <= sync_tog;
            if (arm_cnt != '0)
                arm_cnt <= arm_cnt - ARM_W'(1);
        end
    end

    // The snapshot is captured on the edge where evt is seen. The push into
    // the FIFO happens one cycle later. The JTAG side holds ir_in/sr long
    // enough for this capture.
    logic               push_q;
    logic [ENTRY_W-1:0] cap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            push_q <= 1'b0;
            cap_q  <= '0;
        end else begin
            push_q <= evt;
            if (evt)
                cap_q <= {ir_in, sr};
        end
    end

    // Command FIFO
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               full;
    logic               fire;
    logic               do_write;
    logic               drop;
    logic [ENTRY_W-1:0] head;

    assign full      = (level == LVL_W'(DEPTH));
    assign out_valid = (level != '0);
    // No strobe may leave in a reset cycle, even if the queue was non-empty.
    assign fire      = out_valid && out_ready && !reset;
    // When full, a simultaneous pop frees the slot that the write reuses.
    assign do_write  = push_q && (!full || fire);
    assign drop      = push_q && full && !fire;
    assign head      = mem[rd_ptr];
    assign jdo       = out_valid ? head[DATA_W-1:0] : '0;
    assign jir       = out_valid ? head[ENTRY_W-1:DATA_W] : '0;

    always_ff @(posedge clk) begin
        if (do_write && !reset)
            mem[wr_ptr] <= cap_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (fire)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_write && !fire)
                level <= level + LVL_W'(1);
            else if (fire && !do_write)
                level <= level - LVL_W'(1);
        end
    end

    // Drop reporting. A drop in the same cycle as ovf_clr counts as the first
    // drop after the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr)
                drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    // Strobe decode
    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        if (fire) begin
            if (jdo[DATA_W-1])
                take_action[jir] = 1'b1;
            else
                take_no_action[jir] = 1'b1;
        end
    end

endmodule
